// File: rtl/icache_req_arbiter_if.sv
// Request/response bundle between the fetch-side requesters, the icache port
// and icache_req_arbiter. The arbiter connects through the slave modport.
interface icache_req_arbiter_if #(
    parameter int ADDR_W = 40,
    parameter int LINE_W = 128
);
    logic              dem_valid_i;
    logic [ADDR_W-1:0] dem_vaddr_i;
    logic              dem_ready_o;
    logic              pf_valid_i;
    logic [ADDR_W-1:0] pf_vaddr_i;
    logic              pf_ready_o;
    logic              flush_i;
    logic              ic_req_valid_o;
    logic [ADDR_W-1:0] ic_req_vaddr_o;
    logic              ic_req_ready_i;
    logic              ic_req_kill_o;
    logic              ic_resp_valid_i;
    logic [LINE_W-1:0] ic_resp_data_i;
    logic              ic_resp_xcpt_i;
    logic [LINE_W-1:0] resp_data_o;
    logic              resp_xcpt_o;
    logic              dem_resp_valid_o;
    logic              pf_resp_valid_o;
    logic [ADDR_W-1:0] pf_resp_vaddr_o;
    logic              timeout_o;
    logic [15:0]       merge_cnt_o;

    modport slave (
        input  dem_valid_i, dem_vaddr_i, pf_valid_i, pf_vaddr_i, flush_i,
               ic_req_ready_i, ic_resp_valid_i, ic_resp_data_i, ic_resp_xcpt_i,
        output dem_ready_o, pf_ready_o, ic_req_valid_o, ic_req_vaddr_o,
               ic_req_kill_o, resp_data_o, resp_xcpt_o, dem_resp_valid_o,
               pf_resp_valid_o, pf_resp_vaddr_o, timeout_o, merge_cnt_o
    );

    modport master (
        output dem_valid_i, dem_vaddr_i, pf_valid_i, pf_vaddr_i, flush_i,
               ic_req_ready_i, ic_resp_valid_i, ic_resp_data_i, ic_resp_xcpt_i,
        input  dem_ready_o, pf_ready_o, ic_req_valid_o, ic_req_vaddr_o,
               ic_req_kill_o, resp_data_o, resp_xcpt_o, dem_resp_valid_o,
               pf_resp_valid_o, pf_resp_vaddr_o, timeout_o, merge_cnt_o
    );
endinterface

// File: rtl/icache_req_arbiter.sv
// Shares the single icache request port between demand fetch and the next-line
// prefetcher: one outstanding request, demand priority, merge, flush drain, timeout.
module icache_req_arbiter #(
    parameter int ADDR_W  = 40,
    parameter int LINE_W  = 128,
    parameter int OFFS_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    icache_req_arbiter_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;
    typedef enum logic       {OWN_DEM, OWN_PF}         owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [15:0]       merge_cnt_q, merge_cnt_d;
    logic [LINE_W-1:0] resp_data_q, resp_data_d;
    logic              resp_xcpt_q, resp_xcpt_d;
    logic              dem_resp_valid_q, dem_resp_valid_d;
    logic              pf_resp_valid_q, pf_resp_valid_d;

    logic              req_valid, dem_ready, pf_ready, req_kill, timeout;
    logic [ADDR_W-1:0] req_vaddr;
    logic              line_match, timer_hit, merge;

    assign line_match = (bus.dem_vaddr_i[ADDR_W-1:OFFS_W] == addr_q[ADDR_W-1:OFFS_W]);
    assign timer_hit  = (timer_q == TW'(TIMEOUT - 1));

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        addr_d           = addr_q;
        timer_d          = timer_q;
        merge_cnt_d      = merge_cnt_q;
        resp_data_d      = resp_data_q;
        resp_xcpt_d      = resp_xcpt_q;
        dem_resp_valid_d = 1'b0;
        pf_resp_valid_d  = 1'b0;
        req_valid        = 1'b0;
        req_vaddr        = bus.dem_valid_i ? bus.dem_vaddr_i : bus.pf_vaddr_i;
        dem_ready        = 1'b0;
        pf_ready         = 1'b0;
        req_kill         = 1'b0;
        timeout          = 1'b0;
        merge            = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_valid = (bus.dem_valid_i | bus.pf_valid_i) & ~bus.flush_i;
                dem_ready = bus.dem_valid_i & bus.ic_req_ready_i & ~bus.flush_i;
                pf_ready  = bus.pf_valid_i & ~bus.dem_valid_i & bus.ic_req_ready_i & ~bus.flush_i;
                if (dem_ready || pf_ready) begin
                    addr_d  = req_vaddr;
                    owner_d = dem_ready ? OWN_DEM : OWN_PF;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (bus.flush_i) begin
                    // A response coinciding with the flush is simply dropped; nothing left to kill.
                    if (bus.ic_resp_valid_i) begin
                        state_d = S_IDLE;
                    end else begin
                        req_kill = 1'b1;
                        timeout  = timer_hit;
                        state_d  = timer_hit ? S_IDLE : S_DRAIN;
                    end
                end else begin
                    merge = (owner_q == OWN_PF) & bus.dem_valid_i & line_match &
                            (bus.ic_resp_valid_i | ~timer_hit);
                    if (merge) begin
                        dem_ready = 1'b1;
                        owner_d   = OWN_DEM;
                        if (merge_cnt_q != 16'hFFFF) merge_cnt_d = merge_cnt_q + 16'd1;
                    end
                    if (bus.ic_resp_valid_i) begin
                        resp_data_d = bus.ic_resp_data_i;
                        resp_xcpt_d = bus.ic_resp_xcpt_i;
                        if (owner_q == OWN_DEM || merge) dem_resp_valid_d = 1'b1;
                        else                             pf_resp_valid_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (timer_hit) begin
                        timeout  = 1'b1;
                        req_kill = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end

            S_DRAIN: begin
                timer_d = timer_q + TW'(1);
                if (bus.ic_resp_valid_i) begin
                    state_d = S_IDLE;
                end else if (timer_hit) begin
                    timeout  = 1'b1;
                    req_kill = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // The reset cycle abandons whatever is in flight, so no handshake or kill escapes it.
        if (rst_i) begin
            req_valid = 1'b0;
            dem_ready = 1'b0;
            pf_ready  = 1'b0;
            req_kill  = 1'b0;
            timeout   = 1'b0;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            owner_q          <= OWN_DEM;
            addr_q           <= '0;
            timer_q          <= '0;
            merge_cnt_q      <= '0;
            resp_data_q      <= '0;
            resp_xcpt_q      <= 1'b0;
            dem_resp_valid_q <= 1'b0;
            pf_resp_valid_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            addr_q           <= addr_d;
            timer_q          <= timer_d;
            merge_cnt_q      <= merge_cnt_d;
            resp_data_q      <= resp_data_d;
            resp_xcpt_q      <= resp_xcpt_d;
            dem_resp_valid_q <= dem_resp_valid_d;
            pf_resp_valid_q  <= pf_resp_valid_d;
        end
    end

    assign bus.ic_req_valid_o   = req_valid;
    assign bus.ic_req_vaddr_o   = req_vaddr;
    assign bus.dem_ready_o      = dem_ready;
    assign bus.pf_ready_o       = pf_ready;
    assign bus.ic_req_kill_o    = req_kill;
    assign bus.timeout_o        = timeout;
    assign bus.resp_data_o      = resp_data_q;
    assign bus.resp_xcpt_o      = resp_xcpt_q;
    assign bus.dem_resp_valid_o = dem_resp_valid_q;
    assign bus.pf_resp_valid_o  = pf_resp_valid_q;
    assign bus.pf_resp_vaddr_o  = {addr_q[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    assign bus.merge_cnt_o      = merge_cnt_q;
endmodule
